// File: rtl/register_file_2w.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Write port 4 has priority over port 3, both for storage and for read bypass.
module register_file_2w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] a1,
  input  logic [ADDR_WIDTH-1:0] a2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic [ADDR_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0] wd3,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] a4,
  input  logic [DATA_WIDTH-1:0] wd4,
  input  logic                  we4,
  input  logic                  busy_set,
  input  logic [ADDR_WIDTH-1:0] busy_addr,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_busy;

  logic [DEPTH-1:0] w_sel3;
  logic [DEPTH-1:0] w_sel4;
  logic [DEPTH-1:0] w_selb;
  logic [DEPTH-1:0] w_lock;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_sel
    assign w_sel3[gi] = we3 && (a3 == ADDR_WIDTH'(gi));
    assign w_sel4[gi] = we4 && (a4 == ADDR_WIDTH'(gi));
    assign w_selb[gi] = busy_set && (busy_addr == ADDR_WIDTH'(gi));
    assign w_lock[gi] = (ZERO_REG != 0) && (gi == 0);
  end

  // A new producer (busy_set) outranks a retiring write on the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!w_lock[i]) begin
          if (w_sel4[i]) begin
            r_mem[i] <= wd4;
          end else if (w_sel3[i]) begin
            r_mem[i] <= wd3;
          end
          if (w_selb[i]) begin
            r_busy[i] <= 1'b1;
          end else if (w_sel3[i] || w_sel4[i]) begin
            r_busy[i] <= 1'b0;
          end
        end
      end
    end
  end

  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];
  logic [1:0]            w_rbusy;

  assign w_raddr[0] = a1;
  assign w_raddr[1] = a2;

  for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
    logic w_hit3;
    logic w_hit4;
    logic w_zero;

    assign w_hit3 = (BYPASS != 0) && we3 && (a3 == w_raddr[gi]);
    assign w_hit4 = (BYPASS != 0) && we4 && (a4 == w_raddr[gi]);
    assign w_zero = (ZERO_REG != 0) && (w_raddr[gi] == '0);

    // A bypassed value is already available, so it is never reported busy.
    assign w_rdata[gi] = w_zero ? '0  :
                         w_hit4 ? wd4 :
                         w_hit3 ? wd3 : r_mem[w_raddr[gi]];
    assign w_rbusy[gi] = (w_zero || w_hit4 || w_hit3) ? 1'b0 : r_busy[w_raddr[gi]];
  end

  assign rd1   = w_rdata[0];
  assign rd2   = w_rdata[1];
  assign busy1 = w_rbusy[0];
  assign busy2 = w_rbusy[1];

endmodule

// File: tb/tb_register_file_2w.sv
// Bench for register_file_2w: one instance with zero-register and bypass,
// one with both disabled, driven by the same stimulus and checked per cycle.
module tb_register_file_2w;

  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2, a3, a4, busy_addr;
  logic [31:0] wd3, wd4;
  logic        we3, we4, busy_set;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy1_a, busy2_a, busy1_b, busy2_b;

  int checks   = 0;
  int failures = 0;

  register_file_2w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_a), .rd2(rd2_a),
    .a3(a3), .wd3(wd3), .we3(we3), .a4(a4), .wd4(wd4), .we4(we4),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy1(busy1_a), .busy2(busy2_a)
  );

  register_file_2w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b),
    .a3(a3), .wd3(wd3), .we3(we3), .a4(a4), .wd4(wd4), .we4(we4),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy1(busy1_b), .busy2(busy2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs plus expected outputs: ax_* for instance A, bx_* for instance B.
  typedef struct {
    string name;
    int rst, ra1, ra2, rwe3, ra3, rwd3, rwe4, ra4, rwd4, rbs, rba;
    int ax_rd1, ax_rd2, ax_b1, ax_b2;
    int bx_rd1, bx_rd2, bx_b1, bx_b2;
  } vec_t;

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] rd1, rd2;
    logic        b1, b2;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", name, what, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    reset     = v.rst[0];
    a1        = v.ra1[4:0];
    a2        = v.ra2[4:0];
    we3       = v.rwe3[0];
    a3        = v.ra3[4:0];
    wd3       = v.rwd3;
    we4       = v.rwe4[0];
    a4        = v.ra4[4:0];
    wd4       = v.rwd4;
    busy_set  = v.rbs[0];
    busy_addr = v.rba[4:0];
    sb_q.push_back('{v.name, 0, v.ax_rd1, v.ax_rd2, v.ax_b1[0], v.ax_b2[0]});
    sb_q.push_back('{v.name, 1, v.bx_rd1, v.bx_rd2, v.bx_b1[0], v.bx_b2[0]});
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        check(e.name, "A.rd1", rd1_a, e.rd1);
        check(e.name, "A.rd2", rd2_a, e.rd2);
        check(e.name, "A.busy1", {31'd0, busy1_a}, {31'd0, e.b1});
        check(e.name, "A.busy2", {31'd0, busy2_a}, {31'd0, e.b2});
      end else begin
        check(e.name, "B.rd1", rd1_b, e.rd1);
        check(e.name, "B.rd2", rd2_b, e.rd2);
        check(e.name, "B.busy1", {31'd0, busy1_b}, {31'd0, e.b1});
        check(e.name, "B.busy2", {31'd0, busy2_b}, {31'd0, e.b2});
      end
    end
    $display("txn %-14s a1=%0d a2=%0d A:rd1=0x%0h rd2=0x%0h b=%b%b B:rd1=0x%0h rd2=0x%0h b=%b%b",
             v.name, a1, a2, rd1_a, rd2_a, busy1_a, busy2_a, rd1_b, rd2_b, busy1_b, busy2_b);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[20];
  vec_t v;

  initial begin
    //            name           rst a1 a2 we3 a3 wd3      we4 a4 wd4     bs ba  A: rd1    rd2   b1 b2  B: rd1   rd2   b1 b2
    tbl[0]  = '{"dual_wr",       0,  5, 9, 1,  5, 'hAAAA,  1,  9, 'h5555, 0, 0,  'hAAAA, 'h5555, 0, 0,  105,    109,    0, 0};
    tbl[1]  = '{"dual_rd",       0,  5, 9, 0,  0, 0,       0,  0, 0,      0, 0,  'hAAAA, 'h5555, 0, 0,  'hAAAA, 'h5555, 0, 0};
    tbl[2]  = '{"collide",       0,  7, 8, 1,  7, 1,       1,  7, 2,      0, 0,  2,      108,    0, 0,  107,    108,    0, 0};
    tbl[3]  = '{"collide_rd",    0,  7, 7, 0,  0, 0,       0,  0, 0,      0, 0,  2,      2,      0, 0,  2,      2,      0, 0};
    tbl[4]  = '{"bypass",        0, 12,12, 1, 12, 'h1234,  0,  0, 0,      0, 0,  'h1234, 'h1234, 0, 0,  112,    112,    0, 0};
    tbl[5]  = '{"bypass_next",   0, 12, 0, 0,  0, 0,       0,  0, 0,      0, 0,  'h1234, 0,      0, 0,  'h1234, 0,      0, 0};
    tbl[6]  = '{"bset3",         0,  3, 3, 0,  0, 0,       0,  0, 0,      1, 3,  103,    103,    0, 0,  103,    103,    0, 0};
    tbl[7]  = '{"busy3",         0,  3, 4, 0,  0, 0,       0,  0, 0,      0, 0,  103,    104,    1, 0,  103,    104,    1, 0};
    tbl[8]  = '{"wr4_clr",       0,  3, 3, 0,  0, 0,       1,  3, 33,     0, 0,  33,     33,     0, 0,  103,    103,    1, 1};
    tbl[9]  = '{"clr_next",      0,  3, 3, 0,  0, 0,       0,  0, 0,      0, 0,  33,     33,     0, 0,  33,     33,     0, 0};
    tbl[10] = '{"set_and_wr",    0,  3, 3, 1,  3, 44,      0,  0, 0,      1, 3,  44,     44,     0, 0,  33,     33,     0, 0};
    tbl[11] = '{"set_wins",      0,  3, 3, 0,  0, 0,       0,  0, 0,      0, 0,  44,     44,     1, 1,  44,     44,     1, 1};
    tbl[12] = '{"set_diff",      0,  3, 6, 1,  3, 45,      0,  0, 0,      1, 6,  45,     106,    0, 0,  44,     106,    1, 0};
    tbl[13] = '{"set_diff_next", 0,  3, 6, 0,  0, 0,       0,  0, 0,      0, 0,  45,     106,    0, 1,  45,     106,    0, 1};
    tbl[14] = '{"zero_wr",       0,  0, 0, 1,  0, 'hFFFF,  0,  0, 0,      1, 0,  0,      0,      0, 0,  0,      0,      0, 0};
    tbl[15] = '{"zero_rd",       0,  0, 0, 0,  0, 0,       0,  0, 0,      0, 0,  0,      0,      0, 0,  'hFFFF, 'hFFFF, 1, 1};
    tbl[16] = '{"wr4_zero",      0,  0, 6, 0,  0, 0,       1,  0, 5,      0, 0,  0,      106,    0, 1,  'hFFFF, 106,    1, 1};
    tbl[17] = '{"rst_mid",       1,  4, 6, 1,  4, 77,      0,  0, 0,      1, 4,  77,     106,    0, 1,  104,    106,    0, 1};
    tbl[18] = '{"after_rst",     0,  4, 6, 0,  0, 0,       0,  0, 0,      0, 0,  0,      0,      0, 0,  0,      0,      0, 0};
    tbl[19] = '{"after_rst0",    0,  0, 3, 0,  0, 0,       0,  0, 0,      0, 0,  0,      0,      0, 0,  0,      0,      0, 0};

    reset = 1'b1; a1 = '0; a2 = '0; a3 = '0; a4 = '0; wd3 = '0; wd4 = '0;
    we3 = 1'b0; we4 = 1'b0; busy_set = 1'b0; busy_addr = '0;
    @(posedge clk);
    #1;

    // Every address reads zero and idle right after reset.
    for (int i = 0; i < 32; i++) begin
      v = '{"reset_state", 0, i, 31 - i, 0, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0};
      run_vec(v);
    end

    // Fill r[i] = i+100 through port 3; A sees the bypassed value, B the old zero.
    for (int i = 1; i < 32; i++) begin
      v = '{"fill", 0, i, 0, 1, i, i + 100, 0, 0, 0, 0, 0,
            i + 100, 0, 0, 0, 0, 0, 0, 0};
      run_vec(v);
    end

    for (int i = 0; i < 32; i++) begin
      v = '{"readback", 0, i, i, 0, 0, 0, 0, 0, 0, 0, 0,
            (i == 0) ? 0 : i + 100, (i == 0) ? 0 : i + 100, 0, 0,
            (i == 0) ? 0 : i + 100, (i == 0) ? 0 : i + 100, 0, 0};
      run_vec(v);
    end

    for (int k = 0; k < 20; k++) begin
      run_vec(tbl[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_2w.md
Name: register_file_2w

Overview:
Parametrised successor to the single-write-port register file. Two read ports, two write ports and a per-register busy scoreboard, for a core that retires two results per cycle. Optional write-to-read bypass and an optional hardwired-zero register 0. Sits between decode (reads, busy checks) and writeback (two result buses).

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is ordinary
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all registers and all busy bits
a1  input  ADDR_WIDTH  read port 1 address
a2  input  ADDR_WIDTH  read port 2 address
rd1  output  DATA_WIDTH  read port 1 data (combinational)
rd2  output  DATA_WIDTH  read port 2 data (combinational)
a3  input  ADDR_WIDTH  write port 3 address
wd3  input  DATA_WIDTH  write port 3 data
we3  input  1  write port 3 enable
a4  input  ADDR_WIDTH  write port 4 address
wd4  input  DATA_WIDTH  write port 4 data
we4  input  1  write port 4 enable
busy_set  input  1  mark register busy_addr as pending (producer issued)
busy_addr  input  ADDR_WIDTH  register to mark busy
busy1  output  1  pending flag for a1 (combinational)
busy2  output  1  pending flag for a2 (combinational)

Behaviour:
- Storage: DEPTH x DATA_WIDTH registers, plus DEPTH busy bits.
- Reset: on a rising edge with reset=1, all registers go to 0 and all busy bits are cleared. Reset overrides any write or busy_set in that cycle. After that edge: rd1 = rd2 = 0 and busy1 = busy2 = 0 for every address.
- Write, effective at the rising edge:
  - we3=1 stores wd3 into a3; we4=1 stores wd4 into a4.
  - If we3 and we4 are both 1 and a3 == a4, port 4 wins and wd3 is discarded.
- Zero register: when ZERO_REG=1, writes and busy_set to address 0 are ignored; rd reads 0 at address 0 and busy reads 0 for a1/a2 = 0 regardless of BYPASS.
- Read: rdN = mem[aN], combinational, zero-latency.
- Bypass: when BYPASS=1, rdN is overridden by same-cycle write data:
  - rdN = wd4 if we4 and a4 == aN.
  - Otherwise rdN = wd3 if we3 and a3 == aN.
  - Otherwise rdN = mem[aN].
  - Port 4 priority matches the write-collision rule.
- No bypass: when BYPASS=0, the read returns the old value in the write cycle and the new value from the next cycle.
- Scoreboard, updated at the rising edge:
  - busy_set sets busy[busy_addr].
  - A write on either port clears busy[aw].
  - A simultaneous set and clear of the same address leaves the bit set (a new producer wins over a retiring one).
  - Sets and clears to different addresses in the same cycle all take effect.
- busyN = busy[aN], except when BYPASS=1 and a same-cycle write targets aN: then busyN = 0, so decode can consume the bypassed value.
- Reads to arbitrary addresses never alter state. No internal latency beyond one edge for writes and busy updates.
- Width rules: no truncation; all data paths are DATA_WIDTH. Addresses are full-range, with no out-of-range cases.

Test Plan:
- Reset and fill: assert reset for 1 cycle, then write register i = i+100 via port 3 for i = 1..31. Read each on both ports next cycle -> rd1 = rd2 = i+100. Reading address 0 -> 0.
- Dual write and collision: we3=we4=1, a3=5, wd3=0xAAAA, a4=9, wd4=0x5555 -> next cycle r5 = 0xAAAA, r9 = 0x5555. Then a3=a4=7, wd3=1, wd4=2 -> r7 = 2.
- Bypass: BYPASS=1, a1=a3=12, we3=1, wd3=0x1234, old r12 = 0 -> rd1 = 0x1234 in the same cycle. Repeat with BYPASS=0 -> rd1 = 0 in that cycle and 0x1234 next cycle.
- Scoreboard: busy_set with busy_addr=3 -> busy1 = 1 for a1=3 next cycle. Write r3 via port 4 -> busy1 = 0 (same cycle with BYPASS=1, next cycle with BYPASS=0). busy_set and we3 to address 3 in the same cycle -> busy stays 1.
- Zero register: ZERO_REG=1, write 0xFFFF to address 0 and busy_set address 0 -> rd1 = 0 and busy1 = 0 for a1=0. ZERO_REG=0 -> rd1 = 0xFFFF.
- Mid-operation reset: reset=1 with we3=1 (a3=4, wd3=77) and busy_set to address 4 -> next cycle r4 = 0 and busy = 0.
